mmio_io_unit: RTL and testbench

Memory-mapped I/O back end driven by the decode-stage control strobes (UART read/write enables, UART status select, counter select/reset, read-data source select). It holds a UART transmit holding register, a small UART receive FIFO, and the 32-bit cycle and instruction counters. It returns a registered 32-bit read word to the writeback read-data mux one cycle after the access.

---
 rtl/mmio_io_unit.sv | 136 +++++++++++++
 tb/tb_mmio_io_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mmio_io_unit.sv
`default_nettype none
// ============================================================================
// mmio_io_unit: UART TX holding register, RX FIFO and cycle/instruction
// counters behind decode-stage MMIO strobes, with a registered read word.
// Revision: 1.0
// ============================================================================
module mmio_io_unit #(
  parameter int RX_DEPTH = 4,
  parameter int CNT_W    = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        io_rd,
  input  logic [1:0]  rd_sel,
  input  logic [1:0]  uart_sel,
  input  logic        uart_re,
  input  logic        uart_we,
  input  logic [7:0]  wdata,
  input  logic        ct_sel,
  input  logic        ct_reset,
  input  logic        instr_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [31:0] io_rdata,
  output logic        tx_overrun
);

  localparam int AW = $clog2(RX_DEPTH);

  logic [7:0]       fifo_mem [RX_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] ins_cnt;
  logic [31:0]      cyc_word;
  logic [31:0]      ins_word;
  logic [31:0]      uart_word;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic             handoff;
  logic             tx_accept;

  // Depth is a power of two, so the count MSB alone marks "full".
  assign empty     = (count == '0);
  assign full      = count[AW];
  assign rx_ready  = !full;
  assign push      = rx_valid && !full;
  assign pop       = uart_re && !empty;
  assign handoff   = tx_valid && tx_ready;
  assign tx_accept = uart_we && (!tx_valid || handoff);

  generate
    if (CNT_W < 32) begin : g_cnt_ext
      assign cyc_word = {{(32-CNT_W){1'b0}}, cyc_cnt};
      assign ins_word = {{(32-CNT_W){1'b0}}, ins_cnt};
    end else begin : g_cnt_full
      assign cyc_word = cyc_cnt[31:0];
      assign ins_word = ins_cnt[31:0];
    end
  endgenerate

  always_comb begin
    uart_word = 32'd0;
    case (uart_sel)
      2'b00:   uart_word = empty ? 32'd0 : {24'd0, fifo_mem[rd_ptr]};
      2'b01:   uart_word = {31'd0, !tx_valid};
      2'b10:   uart_word = {31'd0, !empty};
      default: uart_word = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_data    <= 8'd0;
      tx_valid   <= 1'b0;
      tx_overrun <= 1'b0;
    end else begin
      if (tx_accept) begin
        tx_data  <= wdata;
        tx_valid <= 1'b1;
      end else if (handoff) begin
        tx_valid <= 1'b0;
      end
      if (uart_we && !tx_accept) tx_overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_cnt <= '0;
      ins_cnt <= '0;
    end else if (ct_reset) begin
      cyc_cnt <= '0;
      ins_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 1'b1;
      if (instr_valid) ins_cnt <= ins_cnt + 1'b1;
    end
  end

  // Counter reads see the value from before this edge's increment or clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      io_rdata <= 32'd0;
    end else if (io_rd) begin
      if (rd_sel == 2'b00)      io_rdata <= uart_word;
      else if (rd_sel == 2'b11) io_rdata <= ct_sel ? ins_word : cyc_word;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mmio_io_unit.sv
`default_nettype none
// Directed self-checking bench for mmio_io_unit (default instance plus a
// 4-bit counter instance sharing the same stimulus).
module tb_mmio_io_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        io_rd, uart_re, uart_we, ct_sel, ct_reset, instr_valid;
  logic        tx_ready, rx_valid;
  logic [1:0]  rd_sel, uart_sel;
  logic [7:0]  wdata, rx_data;
  logic [7:0]  tx_data, tx_data4;
  logic        tx_valid, tx_valid4, rx_ready, rx_ready4, tx_overrun, tx_overrun4;
  logic [31:0] io_rdata, io_rdata4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mmio_io_unit dut (
    .clk(clk), .reset_n(reset_n), .io_rd(io_rd), .rd_sel(rd_sel),
    .uart_sel(uart_sel), .uart_re(uart_re), .uart_we(uart_we), .wdata(wdata),
    .ct_sel(ct_sel), .ct_reset(ct_reset), .instr_valid(instr_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .io_rdata(io_rdata), .tx_overrun(tx_overrun)
  );

  mmio_io_unit #(.RX_DEPTH(4), .CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .io_rd(io_rd), .rd_sel(rd_sel),
    .uart_sel(uart_sel), .uart_re(uart_re), .uart_we(uart_we), .wdata(wdata),
    .ct_sel(ct_sel), .ct_reset(ct_reset), .instr_valid(instr_valid),
    .tx_data(tx_data4), .tx_valid(tx_valid4), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready4),
    .io_rdata(io_rdata4), .tx_overrun(tx_overrun4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    io_rd = 0; rd_sel = 2'b01; uart_sel = 0; uart_re = 0; uart_we = 0;
    wdata = 0; ct_sel = 0; ct_reset = 0; instr_valid = 0; rx_valid = 0;
    rx_data = 0;
  endtask

  initial begin
    idle();
    tx_ready = 0;
    reset_n  = 0;
    step(); step();
    check("rst_io_rdata", io_rdata, 32'd0);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    check("rst_overrun", {31'd0, tx_overrun}, 32'd0);

    // 1: cycle counter read and clear
    reset_n = 1;
    repeat (10) step();
    io_rd = 1; rd_sel = 2'b11; ct_sel = 0;
    step();
    check("cyc_read_10", io_rdata, 32'd10);
    io_rd = 0; ct_reset = 1;
    step();
    ct_reset = 0; io_rd = 1;
    step();
    check("cyc_after_clear", io_rdata, 32'd0);
    io_rd = 0;
    step();

    // 2: TX holding register and overrun
    uart_we = 1; wdata = 8'h41;
    step();
    check("tx_first_valid", {31'd0, tx_valid}, 32'd1);
    wdata = 8'h42;
    step();
    check("tx_drop_data", {24'd0, tx_data}, 32'h41);
    check("tx_overrun_set", {31'd0, tx_overrun}, 32'd1);
    uart_we = 0; io_rd = 1; rd_sel = 2'b00; uart_sel = 2'b01;
    step();
    check("tx_status_busy", io_rdata, 32'd0);
    io_rd = 0; tx_ready = 1;
    step();
    check("tx_handoff_drop", {31'd0, tx_valid}, 32'd0);
    uart_we = 1; wdata = 8'h50;
    step();
    check("tx_new_byte", {24'd0, tx_data}, 32'h50);
    wdata = 8'h43;
    step();
    check("tx_handoff_write", {24'd0, tx_data}, 32'h43);
    check("tx_handoff_valid", {31'd0, tx_valid}, 32'd1);
    uart_we = 0;
    step();
    io_rd = 1; rd_sel = 2'b00; uart_sel = 2'b01;
    step();
    check("tx_status_ready", io_rdata, 32'd1);
    check("tx_overrun_sticky", {31'd0, tx_overrun}, 32'd1);
    idle(); tx_ready = 0;

    // 3: fill, overflow attempt and drain
    rx_valid = 1;
    rx_data = 8'h11; step();
    rx_data = 8'h22; step();
    rx_data = 8'h33; step();
    check("rx_ready_at_3", {31'd0, rx_ready}, 32'd1);
    rx_data = 8'h44; step();
    check("rx_full", {31'd0, rx_ready}, 32'd0);
    rx_data = 8'h99; step();
    rx_valid = 0; io_rd = 1; rd_sel = 2'b00; uart_sel = 2'b10;
    step();
    check("rx_status_full", io_rdata, 32'd1);
    uart_sel = 2'b00; uart_re = 1;
    step(); check("pop_1", io_rdata, 32'h11);
    check("rx_ready_after_pop", {31'd0, rx_ready}, 32'd1);
    step(); check("pop_2", io_rdata, 32'h22);
    step(); check("pop_3", io_rdata, 32'h33);
    step(); check("pop_4", io_rdata, 32'h44);
    uart_re = 0; uart_sel = 2'b10;
    step(); check("rx_status_empty", io_rdata, 32'd0);
    uart_re = 1; uart_sel = 2'b00;
    step(); check("pop_empty", io_rdata, 32'd0);
    uart_re = 0; uart_sel = 2'b10;
    step(); check("rx_still_empty", io_rdata, 32'd0);
    idle();

    // 4: simultaneous push/pop and pointer wrap
    rx_valid = 1;
    rx_data = 8'hA1; step();
    rx_data = 8'hA2; step();
    rx_data = 8'h55; uart_re = 1; io_rd = 1; rd_sel = 2'b00; uart_sel = 2'b00;
    step(); check("pushpop_head", io_rdata, 32'hA1);
    rx_valid = 0;
    step(); check("pushpop_2nd", io_rdata, 32'hA2);
    step(); check("pushpop_3rd", io_rdata, 32'h55);
    step(); check("pushpop_empty", io_rdata, 32'd0);
    idle();
    rx_valid = 1; rx_data = 8'h60;
    step();
    uart_re = 1; io_rd = 1; rd_sel = 2'b00; uart_sel = 2'b00;
    for (int i = 1; i <= 10; i++) begin
      rx_data = 8'h60 + 8'(i);
      step();
      check("wrap_order", io_rdata, 32'h60 + 32'(i - 1));
    end
    rx_valid = 0;
    step(); check("wrap_last", io_rdata, 32'h6A);
    idle();

    // 5: instruction counter wrap on the 4-bit instance, clear priority
    ct_reset = 1;
    step();
    ct_reset = 0; instr_valid = 1;
    repeat (17) step();
    instr_valid = 0; io_rd = 1; rd_sel = 2'b11; ct_sel = 1;
    step();
    check("ins_wrap_cnt4", io_rdata4, 32'd1);
    check("ins_17_cnt32", io_rdata, 32'd17);
    ct_reset = 1; instr_valid = 1;
    step();
    check("ins_preclear_read", io_rdata, 32'd17);
    ct_reset = 0; instr_valid = 0;
    step();
    check("ins_clear_wins", io_rdata, 32'd0);
    check("ins_clear_cnt4", io_rdata4, 32'd0);
    idle();

    // 6: asynchronous reset mid-stream
    rx_valid = 1;
    rx_data = 8'h01; step();
    rx_data = 8'h02; step();
    rx_data = 8'h03; step();
    rx_valid = 0; uart_we = 1; wdata = 8'h77;
    step();
    uart_we = 0; io_rd = 1; rd_sel = 2'b11; ct_sel = 0;
    step();
    idle();
    check("pre_rst_tx_valid", {31'd0, tx_valid}, 32'd1);
    check("pre_rst_rdata_nz", {31'd0, (io_rdata != 0)}, 32'd1);
    @(posedge clk);
    #2 reset_n = 0;
    #1;
    check("arst_io_rdata", io_rdata, 32'd0);
    check("arst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("arst_tx_data", {24'd0, tx_data}, 32'd0);
    check("arst_overrun", {31'd0, tx_overrun}, 32'd0);
    check("arst_rx_ready", {31'd0, rx_ready}, 32'd1);
    step();
    reset_n = 1;
    io_rd = 1; rd_sel = 2'b00; uart_sel = 2'b10;
    step();
    check("arst_fifo_empty", io_rdata, 32'd0);
    idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
